// File: rtl/nx_stream_skid_buffer_pkg.sv
// ---------------------------------------------------------------------------
// nx_stream_skid_buffer_pkg
//
// Purpose: shared constants for the nexus stream skid buffer. Designs that
// already carry a common width constant can override STREAM_WIDTH at the
// instance instead of using the default here.
//
// Contents:
//   NX_STREAM_WIDTH - default message data width in bits.
// ---------------------------------------------------------------------------
package nx_stream_skid_buffer_pkg;

   localparam int unsigned NX_STREAM_WIDTH = 32;

endpackage : nx_stream_skid_buffer_pkg

// File: rtl/nx_stream_skid_buffer.sv
// ---------------------------------------------------------------------------
// nx_stream_skid_buffer
//
// Purpose: two-entry skid buffer for a valid/ready message stream. Every
// output is driven straight from a flop, so no combinational path runs
// between producer and consumer in either direction. It sustains one message
// per cycle and keeps strict FIFO order.
//
// Ports:
//   clk_i            - clock, all state updates on the rising edge.
//   rst_i            - asynchronous active-low reset (low = reset).
//   inbound_data_i   - message from upstream.
//   inbound_valid_i  - upstream presents a message.
//   inbound_ready_o  - buffer can accept (registered).
//   outbound_data_o  - message to downstream (registered).
//   outbound_valid_o - message present on outbound_data_o (registered).
//   outbound_ready_i - downstream accepts this cycle.
// ---------------------------------------------------------------------------
module nx_stream_skid_buffer
   import nx_stream_skid_buffer_pkg::*;
#(
   parameter int unsigned STREAM_WIDTH = NX_STREAM_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [STREAM_WIDTH-1:0] inbound_data_i,
   input  logic                    inbound_valid_i,
   output logic                    inbound_ready_o,
   output logic [STREAM_WIDTH-1:0] outbound_data_o,
   output logic                    outbound_valid_o,
   input  logic                    outbound_ready_i
);

   logic                    out_valid_q, out_valid_d;
   logic [STREAM_WIDTH-1:0] out_data_q,  out_data_d;
   logic                    skid_valid_q, skid_valid_d;
   logic [STREAM_WIDTH-1:0] skid_data_q,  skid_data_d;
   logic                    rdy_q, rdy_d;

   logic accept;
   logic out_free;

   assign accept   = inbound_valid_i & rdy_q;
   // The output register can be loaded this edge if it is empty or is
   // being taken by downstream at the same edge.
   assign out_free = ~out_valid_q | outbound_ready_i;

   // Next-state selection in priority order. The skid entry is older than
   // anything upstream can offer, so it always moves first; ready is low
   // whenever the skid is occupied, so no accept can coincide with that move.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      if (skid_valid_q && out_free) begin
         out_data_d   = skid_data_q;
         out_valid_d  = 1'b1;
         skid_valid_d = 1'b0;
      end else if (accept && out_free) begin
         // Includes take-and-accept with an occupied output register: the
         // new message replaces the output directly and bypasses the skid.
         out_data_d  = inbound_data_i;
         out_valid_d = 1'b1;
      end else if (accept) begin
         skid_data_d  = inbound_data_i;
         skid_valid_d = 1'b1;
      end else if (out_free) begin
         out_valid_d = 1'b0;
      end

      // Ready is registered from the next skid state, so it drops the cycle
      // after the skid fills and rises the cycle after it drains.
      rdy_d = ~skid_valid_d;
   end

   // State flops. Reset discards every held message at once and keeps ready
   // low until the first edge after reset is released.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         rdy_q        <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         rdy_q        <= rdy_d;
      end
   end

   assign inbound_ready_o  = rdy_q;
   assign outbound_data_o  = out_data_q;
   assign outbound_valid_o = out_valid_q;

endmodule : nx_stream_skid_buffer

// File: tb/tb_nx_stream_skid_buffer.sv
// ---------------------------------------------------------------------------
// tb_nx_stream_skid_buffer
//
// Purpose: self-checking bench for nx_stream_skid_buffer. Accepted inbound
// messages are pushed into a scoreboard queue; an independent monitor pops
// and compares whenever a message is taken on the outbound side, and checks
// that a stalled output holds steady. Directed checks add hand-computed
// values for reset, latency, backpressure, drain and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_nx_stream_skid_buffer;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   int total;
   int bad;

   logic [W-1:0] sbq[$];

   logic         hold_pend;
   logic [W-1:0] hold_data;

   nx_stream_skid_buffer #(.STREAM_WIDTH(W)) dut (
      .clk_i            (clk),
      .rst_i            (rst_n),
      .inbound_data_i   (in_data),
      .inbound_valid_i  (in_valid),
      .inbound_ready_o  (in_ready),
      .outbound_data_o  (out_data),
      .outbound_valid_o (out_valid),
      .outbound_ready_i (out_ready)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic rdy);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard producer: whatever the buffer accepts must come out in order.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         sbq.push_back(in_data);
   end

   // Scoreboard consumer plus stability check of a stalled output.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_data", out_data, hold_data);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_unexpected: got %0h expected no output", out_data);
            end else begin
               checkOutput("sb_data", out_data, sbq.pop_front());
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_data = out_data;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic         acc;
      logic [W-1:0] cnt;
      int           waited;

      total     = 0;
      bad       = 0;
      hold_pend = 1'b0;
      hold_data = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset held for five cycles.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'd0, 1'b0);
         checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
         checkOutput("rst_data", out_data, 32'd0);
      end
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

      // Pass-through with one cycle latency.
      applyStimulus(1'b1, 32'h11, 1'b1);
      checkOutput("pt_valid0", {31'd0, out_valid}, 32'd1);
      checkOutput("pt_data0", out_data, 32'h11);
      checkOutput("pt_ready0", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'h22, 1'b1);
      checkOutput("pt_data1", out_data, 32'h22);
      checkOutput("pt_ready1", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'h33, 1'b1);
      checkOutput("pt_data2", out_data, 32'h33);
      checkOutput("pt_ready2", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("pt_empty", {31'd0, out_valid}, 32'd0);

      // Backpressure fill.
      applyStimulus(1'b1, 32'hA0, 1'b0);
      checkOutput("bp_data0", out_data, 32'hA0);
      checkOutput("bp_ready0", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'hA1, 1'b0);
      checkOutput("bp_data1", out_data, 32'hA0);
      checkOutput("bp_ready_drop", {31'd0, in_ready}, 32'd0);
      applyStimulus(1'b1, 32'hA2, 1'b0);
      checkOutput("bp_hold", out_data, 32'hA0);
      checkOutput("bp_qdepth", 32'(sbq.size()), 32'd2);
      applyStimulus(1'b1, 32'hA2, 1'b0);
      checkOutput("bp_ready_low", {31'd0, in_ready}, 32'd0);

      // Drain: A0 leaves, skid A1 moves up, ready returns, A2 follows.
      applyStimulus(1'b1, 32'hA2, 1'b1);
      checkOutput("dr_data1", out_data, 32'hA1);
      checkOutput("dr_ready_back", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'hA2, 1'b1);
      checkOutput("dr_data2", out_data, 32'hA2);
      checkOutput("dr_valid2", {31'd0, out_valid}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("dr_empty", {31'd0, out_valid}, 32'd0);
      checkOutput("dr_qempty", 32'(sbq.size()), 32'd0);

      // Random valid/ready with an incrementing pattern.
      cnt = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = cnt;
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) cnt = cnt + 1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waited = 0;
      while (sbq.size() != 0 && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput("rnd_drained", 32'(sbq.size()), 32'd0);
      checkOutput("rnd_empty", {31'd0, out_valid}, 32'd0);

      // Fill, then reset mid-stream between clock edges.
      applyStimulus(1'b1, 32'hB0, 1'b0);
      applyStimulus(1'b1, 32'hB1, 1'b0);
      in_valid = 1'b0;
      checkOutput("mr_full_ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      checkOutput("mr_async_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mr_async_ready", {31'd0, in_ready}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("mr_ready_back", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'h55, 1'b1);
      checkOutput("mr_valid55", {31'd0, out_valid}, 32'd1);
      checkOutput("mr_data55", out_data, 32'h55);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("mr_empty", {31'd0, out_valid}, 32'd0);
      checkOutput("mr_qempty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_nx_stream_skid_buffer
